// File: rtl/fma16_pkg.sv
// Shared types and constants for the fma16 scheduler slice.
//   op_t      : request opcodes understood by the scheduler (5..7 are illegal)
//   state_t   : scheduler FSM states
//   dec_t     : decoded datapath operands/controls plus a legal flag
//   decode_op : maps an opcode and raw operands to datapath inputs
package fma16_pkg;

  typedef enum logic [2:0] {
    OP_FMA  = 3'd0,
    OP_MUL  = 3'd1,
    OP_ADD  = 3'd2,
    OP_FMS  = 3'd3,
    OP_FNMA = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

  localparam logic [15:0] ONE_H    = 16'h3C00;
  localparam logic [15:0] QNAN_H   = 16'h7E00;
  localparam logic [3:0]  FLAG_INV = 4'b1000;

  typedef struct packed {
    logic        legal;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic        mul;
    logic        add;
    logic        negp;
    logic        negz;
  } dec_t;

  function automatic dec_t decode_op(input logic [2:0]  op,
                                     input logic [15:0] x,
                                     input logic [15:0] y,
                                     input logic [15:0] z);
    dec_t d;
    d = '{legal: 1'b1, x: x, y: y, z: z,
          mul: 1'b1, add: 1'b1, negp: 1'b0, negz: 1'b0};
    case (op)
      OP_FMA:  ;
      OP_MUL:  begin d.z = '0;    d.add = 1'b0; end
      OP_ADD:  begin d.y = ONE_H; d.mul = 1'b0; end
      OP_FMS:  d.negz = 1'b1;
      OP_FNMA: d.negp = 1'b1;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/fma16_rr_arb.sv
// Two-way round-robin arbiter.
//   clk, reset_n : clock, asynchronous active-low reset
//   valid[1:0]   : requester valids
//   en           : arbitration enable (scheduler idle)
//   grant[1:0]   : one-hot or zero grant, used directly as req_ready
module fma16_rr_arb (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    grant = '0;
    if (en) begin
      if (valid == 2'b11) grant = last_grant_q ? 2'b01 : 2'b10;
      else                grant = valid;
    end
    // A grant is only ever given to a valid requester, so every grant
    // is also a completed handshake.
    last_grant_d = last_grant_q;
    if (|grant) last_grant_d = grant[1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_grant_q <= 1'b1;
    else          last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/fma16_sched.sv
// Scheduler/sequencer for the shared fma16 datapath.
//   req_*    : two valid/ready request ports (operands, opcode, roundmode)
//   fma_*    : registered operands/controls to the datapath; fma_result and
//              fma_flags are sampled after LAT cycles of stable operands
//   resp_*   : tagged response port (valid/ready)
//   busy     : high whenever not idle
//   op_count : completed responses, wraps at 2^16
module fma16_sched
  import fma16_pkg::*;
#(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_x0,
  input  logic [15:0] req_y0,
  input  logic [15:0] req_z0,
  input  logic [15:0] req_x1,
  input  logic [15:0] req_y1,
  input  logic [15:0] req_z1,
  input  logic [2:0]  req_op0,
  input  logic [2:0]  req_op1,
  input  logic [1:0]  req_rm0,
  input  logic [1:0]  req_rm1,
  output logic [15:0] fma_x,
  output logic [15:0] fma_y,
  output logic [15:0] fma_z,
  output logic        fma_mul,
  output logic        fma_add,
  output logic        fma_negp,
  output logic        fma_negz,
  output logic [1:0]  fma_rm,
  input  logic [15:0] fma_result,
  input  logic [3:0]  fma_flags,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [15:0] resp_result,
  output logic [3:0]  resp_flags,
  output logic        busy,
  output logic [15:0] op_count
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        id_q, id_d;
  logic [15:0] fma_x_q, fma_x_d, fma_y_q, fma_y_d, fma_z_q, fma_z_d;
  logic        fma_mul_q, fma_mul_d, fma_add_q, fma_add_d;
  logic        fma_negp_q, fma_negp_d, fma_negz_q, fma_negz_d;
  logic [1:0]  fma_rm_q, fma_rm_d;
  logic        resp_valid_q, resp_valid_d, resp_id_q, resp_id_d;
  logic [15:0] resp_result_q, resp_result_d;
  logic [3:0]  resp_flags_q, resp_flags_d;
  logic        busy_q, busy_d;
  logic [15:0] op_count_q, op_count_d;

  logic [1:0]  grant;
  logic        sel;
  logic [1:0]  rm_sel;
  dec_t        dec;

  fma16_rr_arb u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (req_valid),
    .en      (state_q == ST_IDLE),
    .grant   (grant)
  );

  assign sel    = grant[1];
  assign rm_sel = sel ? req_rm1 : req_rm0;
  assign dec    = sel ? decode_op(req_op1, req_x1, req_y1, req_z1)
                      : decode_op(req_op0, req_x0, req_y0, req_z0);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    id_d          = id_q;
    fma_x_d       = fma_x_q;
    fma_y_d       = fma_y_q;
    fma_z_d       = fma_z_q;
    fma_mul_d     = fma_mul_q;
    fma_add_d     = fma_add_q;
    fma_negp_d    = fma_negp_q;
    fma_negz_d    = fma_negz_q;
    fma_rm_d      = fma_rm_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_flags_d  = resp_flags_q;
    op_count_d    = op_count_q;

    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          id_d = sel;
          if (dec.legal) begin
            fma_x_d    = dec.x;
            fma_y_d    = dec.y;
            fma_z_d    = dec.z;
            fma_mul_d  = dec.mul;
            fma_add_d  = dec.add;
            fma_negp_d = dec.negp;
            fma_negz_d = dec.negz;
            fma_rm_d   = rm_sel;
            cnt_d      = 4'(LAT - 1);
            state_d    = ST_EXEC;
          end else begin
            // Illegal opcodes bypass the datapath and leave fma_* untouched.
            resp_id_d     = sel;
            resp_result_d = QNAN_H;
            resp_flags_d  = FLAG_INV;
            resp_valid_d  = 1'b1;
            state_d       = ST_RESP;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          resp_id_d     = id_q;
          resp_result_d = fma_result;
          resp_flags_d  = fma_flags;
          resp_valid_d  = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          op_count_d   = op_count_q + 16'd1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      id_q          <= 1'b0;
      fma_x_q       <= '0;
      fma_y_q       <= '0;
      fma_z_q       <= '0;
      fma_mul_q     <= 1'b0;
      fma_add_q     <= 1'b0;
      fma_negp_q    <= 1'b0;
      fma_negz_q    <= 1'b0;
      fma_rm_q      <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
      busy_q        <= 1'b0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      id_q          <= id_d;
      fma_x_q       <= fma_x_d;
      fma_y_q       <= fma_y_d;
      fma_z_q       <= fma_z_d;
      fma_mul_q     <= fma_mul_d;
      fma_add_q     <= fma_add_d;
      fma_negp_q    <= fma_negp_d;
      fma_negz_q    <= fma_negz_d;
      fma_rm_q      <= fma_rm_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_flags_q  <= resp_flags_d;
      busy_q        <= busy_d;
      op_count_q    <= op_count_d;
    end
  end

  assign req_ready   = grant;
  assign fma_x       = fma_x_q;
  assign fma_y       = fma_y_q;
  assign fma_z       = fma_z_q;
  assign fma_mul     = fma_mul_q;
  assign fma_add     = fma_add_q;
  assign fma_negp    = fma_negp_q;
  assign fma_negz    = fma_negz_q;
  assign fma_rm      = fma_rm_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_flags  = resp_flags_q;
  assign busy        = busy_q;
  assign op_count    = op_count_q;

endmodule

// File: doc/fma16_sched.md
# fma16_sched

Two-requester scheduler and sequencer for the shared half-precision FMA datapath (`fma16`). It arbitrates round-robin between two valid/ready request ports and decodes a small opcode into the datapath's control inputs (x, y, z, mul, add, negp, negz, roundmode). The datapath is treated as a multicycle combinational path: the scheduler holds registered operands for `LAT` cycles, samples the result and flags, and returns them on a tagged response port. It sits between the instruction or test front end and the `fma16` datapath.

## Interface
- `LAT`, default 2: cycles operands are held stable before result sampling; legal range 1–15.
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid[1:0]`  in  2  per-requester request valid.
- `req_ready[1:0]`  out  2  per-requester accept; one-hot or zero.
- `req_x0`, `req_y0`, `req_z0`, `req_x1`, `req_y1`, `req_z1`  in  16 each  operands, binary16.
- `req_op0`, `req_op1`  in  3 each  opcode.
- `req_rm0`, `req_rm1`  in  2 each  roundmode.
- `fma_x`, `fma_y`, `fma_z`  out  16 each  datapath operands (registered).
- `fma_mul`, `fma_add`, `fma_negp`, `fma_negz`  out  1 each  datapath controls (registered).
- `fma_rm`  out  2  datapath roundmode (registered).
- `fma_result`  in  16  datapath result.
- `fma_flags`  in  4  datapath flags, ordered {invalid, overflow, underflow, inexact}.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  response accept.
- `resp_id`  out  1  requester index of the response.
- `resp_result`  out  16  result.
- `resp_flags`  out  4  flags.
- `busy`  out  1  high whenever state ≠ IDLE.
- `op_count`  out  16  completed responses; wraps.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- **IDLE:**
  - The arbiter grants one valid requester. With both valid, the grant goes to the one not granted last.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - `req_ready[g]` is high only in IDLE, for the granted g.
  - A handshake (valid & ready) captures the grant id and the decoded controls.
- **Opcode decode:**
  - 0 FMA: x, y, z; mul=1, add=1.
  - 1 MUL: x, y; z=0; mul=1, add=0.
  - 2 ADD: x; y=ONE_H; z; mul=0, add=1.
  - 3 FMS: as FMA with negz=1.
  - 4 FNMA: as FMA with negp=1.
  - 5–7 illegal: the `fma_*` registers are not loaded. Go directly to RESP with result QNAN_H and flags 4'b1000.
- **Legal op:** IDLE→EXEC, with the counter loaded to LAT−1.
  - EXEC decrements the counter each cycle.
  - At counter 0, capture `fma_result`/`fma_flags` into the response registers and go to RESP.
- **RESP:**
  - `resp_valid`=1; all `resp_*` outputs are stable until the handshake.
  - On `resp_ready`: go to IDLE and increment `op_count` (mod 2^16).
  - No request is accepted in RESP or EXEC.
- Requesters hold valid and payload stable until ready (requester obligation; the bench asserts it). The scheduler never retracts ready within a cycle.
- `req_valid` dropping without a handshake has no effect.

## Timing
- Handshake in cycle t → `fma_*` valid from t+1, held through t+LAT.
- Result sampled at the end of t+LAT; `resp_valid` high from t+LAT+1.
- Illegal op: `resp_valid` high from t+1.
- Minimum issue interval is LAT+2 cycles with `resp_ready` tied high.
- **Reset values:**
  - State IDLE; `req_ready` 0 while `req_valid` is 0.
  - `fma_*` all 0; `resp_valid` 0; `resp_id`, `resp_result`, `resp_flags` 0.
  - `busy` 0; `op_count` 0; `last_grant` 1.
- Reset asserted mid-EXEC or mid-RESP: the in-flight op is dropped silently and all outputs take their reset values asynchronously.

## Structure
- `fma16_pkg` holds:
  - the `op_t` enum (FMA, MUL, ADD, FMS, FNMA);
  - the `state_t` enum;
  - ONE_H=16'h3C00, QNAN_H=16'h7E00, FLAG_INV=4'b1000.
- Sub-module `fma16_rr_arb`: 2-way round-robin arbiter. Its inputs are valid[1:0] and an enable (state==IDLE); it returns grant[1:0] and updates `last_grant` on handshake.
- Decode, counter and FSM live in `fma16_sched`; the `fma16` datapath itself is instantiated outside.

## Test plan
- **Single FMA:** req0 op0, x=3C00, y=4000, z=3C00, LAT=2, model returns 4200 → at t+1 `fma_*`=3C00/4000/3C00 with mul=add=1; at t+3 resp_valid=1, id=0, result=4200.
- **Contention:** both requesters valid continuously for 4 ops → grant order 0, 1, 0, 1; `op_count`=4.
- **ADD decode:** req1 op2, x=4000, z=3C00 → `fma_y`=3C00, mul=0, add=1; response id=1.
- **Illegal op:** req0 op=7 → at t+1 resp_result=7E00, flags=1000; `fma_*` unchanged.
- **Response backpressure:** `resp_ready`=0 for 5 cycles with req1 valid → resp outputs stable, `req_ready`=0. On ready, the next cycle req1 is granted.
- **Reset mid-EXEC:** `reset_n` low at t+1 → outputs at reset values immediately; after release, `busy`=0, `op_count`=0, and a fresh req0 completes normally.
